// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: widths, divider state encoding
// and the full-adder cell used by the adder and subtractor.
package arith_pkg;

  localparam int W    = 16;
  localparam int ITER = 16;

  localparam logic [W-1:0] DIVZ_Q = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/csa_sub17.sv
// 17-bit combinational subtractor: a + ~b + 1, built from 4-bit carry-select
// groups over the shared full-adder cell, plus a single top bit.
module csa_sub17
  import arith_pkg::*;
(
  input  logic [16:0] a,
  input  logic [16:0] b,
  output logic [16:0] diff
);

  logic [16:0] bn;
  logic [3:0]  s0, s1;
  logic [1:0]  fa0, fa1;
  logic        c0, c1, carry;

  assign bn = ~b;

  always_comb begin
    diff  = '0;
    s0    = '0;
    s1    = '0;
    fa0   = '0;
    fa1   = '0;
    carry = 1'b1;
    for (int g = 0; g < 4; g++) begin
      // Each group precomputes both carry-in cases; the incoming carry selects.
      c0 = 1'b0;
      c1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
        fa0   = fa(a[4*g+i], bn[4*g+i], c0);
        fa1   = fa(a[4*g+i], bn[4*g+i], c1);
        s0[i] = fa0[0];
        s1[i] = fa1[0];
        c0    = fa0[1];
        c1    = fa1[1];
      end
      diff[4*g +: 4] = carry ? s1 : s0;
      carry          = carry ? c1 : c0;
    end
    diff[16] = a[16] ^ bn[16] ^ carry;
  end

endmodule

// File: rtl/seq_div16.sv
// Sequential 16-bit unsigned restoring divider with start/busy/done handshake.
//  state | meaning
//  IDLE  | waiting for start; results held
//  RUN   | 16 subtract-and-shift iterations, cnt 0..15
//  FIN   | one cycle, done = 1
module seq_div16
  import arith_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         divz
);

  div_state_t  state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] d, v;
  logic [16:0] p;
  logic [16:0] t, diff;
  logic        qbit;
  logic [16:0] p_nxt;

  assign t     = {p[15:0], d[15]};
  assign qbit  = ~diff[16];
  assign p_nxt = qbit ? diff : t;

  csa_sub17 u_sub (
    .a    (t),
    .b    ({1'b0, v}),
    .diff (diff)
  );

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: state_nxt = !start ? IDLE : ((b != '0) ? RUN : FIN);
      RUN:  state_nxt = (cnt == 4'(ITER - 1)) ? FIN : RUN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      d    <= '0;
      v    <= '0;
      p    <= '0;
      q    <= '0;
      r    <= '0;
      divz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && b != '0) begin
            d    <= a;
            v    <= b;
            p    <= '0;
            cnt  <= '0;
            divz <= 1'b0;
          end else if (start) begin
            q    <= DIVZ_Q;
            r    <= a;
            divz <= 1'b1;
          end
        end
        RUN: begin
          p   <= p_nxt;
          d   <= {d[14:0], qbit};
          cnt <= cnt + 4'd1;
          if (cnt == 4'(ITER - 1)) begin
            q <= {d[14:0], qbit};
            r <= p_nxt[15:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded from the state register only, so no input reaches these combinationally.
  assign busy = (state == RUN) || (state == FIN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_seq_div16.sv
// Scoreboard bench for seq_div16: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_seq_div16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [15:0] q, r;
  logic        busy, done, divz;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] eq;
    logic [15:0] er;
    logic        ez;
    int          drv;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_div16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .divz  (divz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", 32'(q), 32'(e.eq));
        check("r", 32'(r), 32'(e.er));
        check("divz", 32'(divz), 32'(e.ez));
        check("latency", 32'(cyc - e.drv), 32'(e.lat));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic push,
                       input logic [15:0] eq, input logic [15:0] er, input logic ez);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    a = ia;
    b = ib;
    start = 1'b1;
    if (push) sb.push_back('{eq, er, ez, cyc, (ib == 16'd0) ? 1 : 17});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;

    #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_divz", 32'(divz), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7 with busy-width measurement
    issue(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_width", 32'(n), 32'd17);

    issue(16'hFFFF, 16'd1, 1'b1, 16'hFFFF, 16'd0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'd1, 16'd0, 1'b0);
    issue(16'd3, 16'd10, 1'b1, 16'd0, 16'd3, 1'b0);

    // Divide by zero: back in IDLE after E1
    issue(16'd5, 16'd0, 1'b1, 16'hFFFF, 16'd5, 1'b1);
    @(negedge clk);
    check("divz_idle_busy", 32'(busy), 32'd0);
    check("divz_hold", 32'(divz), 32'd1);

    // START during RUN is ignored; start held through FIN is ignored too
    issue(16'd1000, 16'd33, 1'b1, 16'd30, 16'd10, 1'b0);
    repeat (4) @(negedge clk);
    a = 16'd1; b = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ign_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_ignored_busy", 32'(busy), 32'd0);
    issue(16'd77, 16'd7, 1'b1, 16'd11, 16'd0, 1'b0);
    check("first_idle_accept", 32'(busy), 32'd1);

    // Reset mid-run aborts with no done
    issue(16'd500, 16'd3, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_q", 32'(q), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    issue(16'd500, 16'd3, 1'b1, 16'd166, 16'd2, 1'b0);

    for (int k = 0; k < 60; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(1, 65535));
      if (k < 20) rb = 16'($urandom_range(1, 15));
      issue(ra, rb, 1'b1, ra / rb, ra % rb, 1'b0);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
